arc4_sequencer: RTL and testbench
=================================

# arc4_sequencer

Sequences one full ARC4 pass over the shared 256×8 S memory: init, then ksa, then prga. It holds exclusive ownership of the single S-memory write/address port and multiplexes it to whichever sub-block's phase is active. It sits between the top-level cracking controller (upstream, en/rdy) and the init/ksa/prga instances (downstream, en/rdy each). One instance per parallel cracking lane.

## Interface
Parameters:
- KEY_W, 24, key width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous to clk, active-low.
- en  in  1  start request; accepted only on a cycle where rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  KEY_W  key sampled on the accept cycle.
- abort  in  1  synchronous abort; returns to idle.
- done  out  1  one-cycle pulse when prga completes.
- phase  out  2  0=idle, 1=init, 2=ksa, 3=prga.
- key_q  out  KEY_W  latched key, fed to ksa/prga.
- init_en / ksa_en / prga_en  out  1 each  sub-block start pulses.
- init_rdy / ksa_rdy / prga_rdy  in  1 each  sub-block ready.
- init_addr, init_wrdata / ksa_addr, ksa_wrdata / prga_addr, prga_wrdata  in  8 each  sub-block S-port requests.
- init_wren / ksa_wren / prga_wren  in  1 each.
- s_addr  out  8, s_wrdata  out  8, s_wren  out  1  muxed S-memory port. s_rddata goes directly to all sub-blocks and does not pass through this block.

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT.
- IDLE: rdy=1. On en=1 and abort=0, latch key into key_q and go to INIT_GO.
- X_GO: X_en = X_rdy (combinational). If X_rdy=1, go to X_WAIT. Otherwise stay, with X_en=0. This stall absorbs a sub-block still busy from an aborted run.
- X_WAIT:
  - The entry cycle ignores X_rdy, because sub-blocks drop rdy the cycle after sampling en.
  - On later cycles, X_rdy=1 advances the state: INIT→KSA_GO, KSA→PRGA_GO, PRGA→IDLE with done=1 in the following cycle.
- At most one X_en is high in any cycle. Each en pulse lasts exactly one cycle.
- Mux ownership:
  - INIT_* states route init_addr/wrdata/wren to the S port; KSA_* and PRGA_* states route the corresponding block the same way.
  - In IDLE: s_addr=0, s_wrdata=0, s_wren=0.
  - Requests from non-owning blocks are ignored entirely.
- phase equals the owner encoding. It is registered, from state.
- abort=1 in any state: next state is IDLE. s_wren is forced to 0 in the abort cycle. No done pulse is generated. key_q is retained.
- Simultaneous events:
  - abort with en in IDLE: abort wins; the block stays IDLE and does not latch key.
  - abort with prga_rdy completion: abort wins; no done pulse.
- en or key changes while not IDLE are ignored. key_q is stable for the whole pass.

## Timing
- Reset (rst_n=0 at a clk edge) puts the block in IDLE with rdy=1, done=0, phase=0, key_q=0, all X_en=0, s_wren=0, s_addr=0, s_wrdata=0. Reset wins over all other inputs.
- Accept at edge of cycle c. INIT_GO is in cycle c+1, and init_en is high in c+1 if init_rdy=1.
- A sub-block busy for N cycles (rdy low on cycles after its en) costs N+2 cycles of phase.
- done is registered: it is high in the first IDLE cycle after PRGA_WAIT and coincides with rdy=1.
- Mux outputs are combinational from state plus sub-block inputs. There is no extra latency on S writes.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles. Required: rdy=1, phase=0, done=0, s_wren=0, all X_en=0, key_q=0.
- Full pass: use stubs with busy times init 256, ksa 768, prga 10. Assert en at cycle 0 with key=24'h000155. Required:
  - init_en pulse at cycle 1.
  - key_q=24'h000155.
  - phase=2 from cycle 259 and phase=3 from cycle 1029.
  - done high only at cycle 1041, with rdy=1.
- Mux isolation: in KSA_WAIT, drive ksa_addr=8'h2A, ksa_wrdata=8'h55, ksa_wren=1, and init_wren=1 with init_addr=8'hFF. Required: s_addr=8'h2A, s_wrdata=8'h55, s_wren=1. Then check IDLE outputs s_wren=0.
- Busy ignore: pulse en with key=24'hFFFFFF during INIT_WAIT. Required: no restart, no extra init_en, and key_q unchanged.
- Abort with busy sub-block: assert abort in cycle 300 (inside KSA_WAIT) while the ksa stub stays busy 100 more cycles. Required:
  - phase=0, rdy=1, and s_wren=0 from cycle 301.
  - No done pulse.
  - A restart passes init, then holds in KSA_GO with ksa_en=0 until ksa_rdy=1, then emits a single ksa_en.
- Simultaneous events:
  - abort=1 and en=1 in IDLE: the block stays IDLE and key_q does not change.
  - abort coincident with prga_rdy completion: done stays 0.

Source files
------------

// File: rtl/arc4_sequencer.sv
// arc4_sequencer: runs one ARC4 pass (init -> ksa -> prga) and owns the shared S-memory write port.
// Latency: accept -> INIT_GO next cycle; each phase costs N+2 cycles for an N-cycle sub-block; done registered.
// Backpressure: each X_GO stalls until X_rdy; en accepted only when idle (rdy=1); abort returns to idle.
module arc4_sequencer #(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic [KEY_W-1:0] key,
  input  logic             abort,
  output logic             done,
  output logic [1:0]       phase,
  output logic [KEY_W-1:0] key_q,
  output logic             init_en,
  output logic             ksa_en,
  output logic             prga_en,
  input  logic             init_rdy,
  input  logic             ksa_rdy,
  input  logic             prga_rdy,
  input  logic [7:0]       init_addr,
  input  logic [7:0]       init_wrdata,
  input  logic [7:0]       ksa_addr,
  input  logic [7:0]       ksa_wrdata,
  input  logic [7:0]       prga_addr,
  input  logic [7:0]       prga_wrdata,
  input  logic             init_wren,
  input  logic             ksa_wren,
  input  logic             prga_wren,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wrdata,
  output logic             s_wren
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INIT_GO   = 3'd1;
  localparam logic [2:0] S_INIT_WAIT = 3'd2;
  localparam logic [2:0] S_KSA_GO    = 3'd3;
  localparam logic [2:0] S_KSA_WAIT  = 3'd4;
  localparam logic [2:0] S_PRGA_GO   = 3'd5;
  localparam logic [2:0] S_PRGA_WAIT = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       wait_first;   // high on the entry cycle of any X_WAIT state
  logic       finish;       // prga completed this cycle (becomes done next cycle)
  logic [1:0] owner;
  logic       sel_wren;

  // Owner encoding of a state: 0 idle, 1 init, 2 ksa, 3 prga.
  function automatic logic [1:0] owner_of(input logic [2:0] s);
    case (s)
      S_INIT_GO, S_INIT_WAIT: owner_of = 2'd1;
      S_KSA_GO,  S_KSA_WAIT:  owner_of = 2'd2;
      S_PRGA_GO, S_PRGA_WAIT: owner_of = 2'd3;
      default:                owner_of = 2'd0;
    endcase
  endfunction

  assign rdy   = (state == S_IDLE);
  assign owner = owner_of(state);

  // Next-state logic and sub-block start pulses; abort overrides everything.
  always_comb begin
    state_nxt = state;
    init_en   = 1'b0;
    ksa_en    = 1'b0;
    prga_en   = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE:      if (en) state_nxt = S_INIT_GO;
      S_INIT_GO: begin
        init_en = init_rdy;
        if (init_rdy) state_nxt = S_INIT_WAIT;
      end
      // The sub-block only drops rdy the cycle after it samples en,
      // so rdy on the entry cycle is stale and must be ignored.
      S_INIT_WAIT: if (!wait_first && init_rdy) state_nxt = S_KSA_GO;
      S_KSA_GO: begin
        ksa_en = ksa_rdy;
        if (ksa_rdy) state_nxt = S_KSA_WAIT;
      end
      S_KSA_WAIT:  if (!wait_first && ksa_rdy) state_nxt = S_PRGA_GO;
      S_PRGA_GO: begin
        prga_en = prga_rdy;
        if (prga_rdy) state_nxt = S_PRGA_WAIT;
      end
      S_PRGA_WAIT: begin
        if (!wait_first && prga_rdy) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default:     state_nxt = S_IDLE;
    endcase
    // Do not launch a sub-block we are about to abandon, and never report completion.
    if (abort) begin
      state_nxt = S_IDLE;
      init_en   = 1'b0;
      ksa_en    = 1'b0;
      prga_en   = 1'b0;
      finish    = 1'b0;
    end
  end

  // State, entry flag, registered phase/done and key latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_first <= 1'b0;
      phase      <= 2'd0;
      done       <= 1'b0;
      key_q      <= '0;
    end else begin
      state      <= state_nxt;
      // Every WAIT state is entered only from its GO state, so any
      // state change marks the first cycle of the new state.
      wait_first <= (state_nxt != state);
      phase      <= owner_of(state_nxt);
      done       <= finish;
      if (state == S_IDLE && en && !abort) key_q <= key;
    end
  end

  // S-port mux: only the owning sub-block reaches the memory; idle drives zeros.
  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    sel_wren = 1'b0;
    case (owner)
      2'd1: begin s_addr = init_addr; s_wrdata = init_wrdata; sel_wren = init_wren; end
      2'd2: begin s_addr = ksa_addr;  s_wrdata = ksa_wrdata;  sel_wren = ksa_wren;  end
      2'd3: begin s_addr = prga_addr; s_wrdata = prga_wrdata; sel_wren = prga_wren; end
      default: ;
    endcase
    s_wren = sel_wren & ~abort;
  end

endmodule

// File: tb/tb_arc4_sequencer.sv
// Bench for arc4_sequencer: busy-counting sub-block stubs, table-driven full passes,
// hand-written corner sequences, and randomized passes checked against a timeline model.
module tb_arc4_sequencer;
  localparam int KEY_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, en, abort;
  logic [KEY_W-1:0] key;
  logic             rdy, done;
  logic [1:0]       phase;
  logic [KEY_W-1:0] key_q;
  logic             init_en, ksa_en, prga_en;
  logic             init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]       init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic             init_wren, ksa_wren, prga_wren;
  logic [7:0]       s_addr, s_wrdata;
  logic             s_wren;

  int vectors = 0;
  int miscompares = 0;

  // Stub sub-blocks: after sampling en, rdy stays low for N cycles.
  int init_n = 1, ksa_n = 1, prga_n = 1;
  int init_cnt, ksa_cnt, prga_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      init_cnt <= 0; ksa_cnt <= 0; prga_cnt <= 0;
    end else begin
      if (init_en && init_cnt == 0) init_cnt <= init_n; else if (init_cnt != 0) init_cnt <= init_cnt - 1;
      if (ksa_en  && ksa_cnt  == 0) ksa_cnt  <= ksa_n;  else if (ksa_cnt  != 0) ksa_cnt  <= ksa_cnt - 1;
      if (prga_en && prga_cnt == 0) prga_cnt <= prga_n; else if (prga_cnt != 0) prga_cnt <= prga_cnt - 1;
    end
  end
  assign init_rdy = (init_cnt == 0);
  assign ksa_rdy  = (ksa_cnt == 0);
  assign prga_rdy = (prga_cnt == 0);

  arc4_sequencer #(.KEY_W(KEY_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .abort(abort),
    .done(done), .phase(phase), .key_q(key_q),
    .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .init_wrdata(init_wrdata),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  typedef struct {
    logic [KEY_W-1:0] k;
    int ni, nk, np;
    int ks, ps, dn;   // expected KSA_GO cycle, PRGA_GO cycle, done cycle
  } pass_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    en = 1'b0; abort = 1'b0;
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
    init_addr = 8'd0; ksa_addr = 8'd0; prga_addr = 8'd0;
    init_wrdata = 8'd0; ksa_wrdata = 8'd0; prga_wrdata = 8'd0;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      idle_in();
    end
  endtask

  task automatic accept(input logic [KEY_W-1:0] kv);
    @(negedge clk);
    idle_in();
    en = 1'b1; key = kv;
  endtask

  // One full pass from accept (cycle 0) to the cycle after done, checked every cycle.
  task automatic run_pass(input logic [KEY_W-1:0] kv, input int ni, input int nk, input int np,
                          input int ks, input int ps, input int dn, input bit noise);
    logic [1:0] o;
    logic [47:0] act, exp;
    logic [7:0] ea, ed;
    logic ew;
    init_n = ni; ksa_n = nk; prga_n = np;
    accept(kv);
    #1;
    chk("accept_rdy", {63'd0, rdy}, 64'd1);
    for (int t = 1; t <= dn + 1; t++) begin
      @(negedge clk);
      idle_in();
      if (noise) begin
        init_addr = 8'($urandom); init_wrdata = 8'($urandom); init_wren = 1'($urandom);
        ksa_addr  = 8'($urandom); ksa_wrdata  = 8'($urandom); ksa_wren  = 1'($urandom);
        prga_addr = 8'($urandom); prga_wrdata = 8'($urandom); prga_wren = 1'($urandom);
        if (t < dn && $urandom_range(0, 3) == 0) begin en = 1'b1; key = KEY_W'($urandom); end
      end
      #1;
      o = (t < ks) ? 2'd1 : (t < ps) ? 2'd2 : (t < dn) ? 2'd3 : 2'd0;
      case (o)
        2'd1: begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
        2'd2: begin ea = ksa_addr;  ed = ksa_wrdata;  ew = ksa_wren;  end
        2'd3: begin ea = prga_addr; ed = prga_wrdata; ew = prga_wren; end
        default: begin ea = 8'd0; ed = 8'd0; ew = 1'b0; end
      endcase
      exp = {o, (o == 2'd0), (t == dn), (t == 1), (t == ks), (t == ps), ew, ea, ed, kv};
      act = {phase, rdy, done, init_en, ksa_en, prga_en, s_wren, s_addr, s_wrdata, key_q};
      chk($sformatf("pass ni=%0d nk=%0d np=%0d t=%0d", ni, nk, np, t), {16'd0, act}, {16'd0, exp});
    end
  endtask

  initial begin
    pass_vec_t tbl[3];
    int cnt, at, dcnt, dat;
    int ni, nk, np;
    logic [KEY_W-1:0] kr;

    tbl[0] = '{k: 24'h000155, ni: 256, nk: 768, np: 10, ks: 259, ps: 1029, dn: 1041};
    tbl[1] = '{k: 24'hABCDEF, ni: 1,   nk: 1,   np: 1,  ks: 4,   ps: 7,    dn: 10};
    tbl[2] = '{k: 24'h123456, ni: 3,   nk: 1,   np: 7,  ks: 6,   ps: 9,    dn: 18};

    // Reset, with busy inputs that must be ignored.
    rst_n = 1'b0; key = 24'h5A5A5A;
    idle_in();
    en = 1'b1; init_wren = 1'b1; init_addr = 8'h33;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rdy",   {63'd0, rdy}, 64'd1);
    chk("reset_phase", {62'd0, phase}, 64'd0);
    chk("reset_done",  {63'd0, done}, 64'd0);
    chk("reset_wren",  {63'd0, s_wren}, 64'd0);
    chk("reset_xen",   {61'd0, init_en, ksa_en, prga_en}, 64'd0);
    chk("reset_key_q", {40'd0, key_q}, 64'd0);
    chk("reset_saddr", {48'd0, s_addr, s_wrdata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();

    // Table-driven full passes.
    for (int i = 0; i < 3; i++)
      run_pass(tbl[i].k, tbl[i].ni, tbl[i].nk, tbl[i].np, tbl[i].ks, tbl[i].ps, tbl[i].dn, 1'b1);

    // Mux isolation in KSA_WAIT (ksa_go at 5), then IDLE drives nothing.
    init_n = 2; ksa_n = 50; prga_n = 2;
    accept(24'h000777);
    adv(10);
    ksa_addr = 8'h2A; ksa_wrdata = 8'h55; ksa_wren = 1'b1;
    init_wren = 1'b1; init_addr = 8'hFF; init_wrdata = 8'h11;
    #1;
    chk("iso_phase",  {62'd0, phase}, 64'd2);
    chk("iso_addr",   {56'd0, s_addr}, 64'h2A);
    chk("iso_wrdata", {56'd0, s_wrdata}, 64'h55);
    chk("iso_wren",   {63'd0, s_wren}, 64'd1);
    dcnt = 0; dat = -1;
    for (int t = 11; t <= 61; t++) begin
      adv(1); #1;
      if (done) begin dcnt++; dat = t; end
    end
    chk("iso_done_cycle", 64'(dat), 64'd61);
    adv(1);
    init_wren = 1'b1; ksa_wren = 1'b1; prga_wren = 1'b1;
    init_addr = 8'h81; ksa_addr = 8'h82; prga_addr = 8'h83;
    init_wrdata = 8'h91; ksa_wrdata = 8'h92; prga_wrdata = 8'h93;
    #1;
    chk("idle_wren",  {63'd0, s_wren}, 64'd0);
    chk("idle_addr",  {56'd0, s_addr}, 64'd0);
    chk("idle_wdata", {56'd0, s_wrdata}, 64'd0);

    // Busy ignore: en with a new key during INIT_WAIT.
    init_n = 5; ksa_n = 1; prga_n = 1;
    accept(24'h0000AA);
    cnt = 0; dcnt = 0; dat = -1;
    for (int t = 1; t <= 15; t++) begin
      adv(1);
      if (t == 3) begin en = 1'b1; key = 24'hFFFFFF; end
      #1;
      if (init_en) cnt++;
      if (done) begin dcnt++; dat = t; end
      if (t == 4) chk("busy_phase", {62'd0, phase}, 64'd1);
    end
    chk("busy_init_en_count", 64'(cnt), 64'd1);
    chk("busy_key_q", {40'd0, key_q}, 64'h0000AA);
    chk("busy_done_cycle", 64'(dat), 64'd14);

    // Abort at cycle 300 inside KSA_WAIT while ksa stays busy until cycle 400.
    init_n = 256; ksa_n = 140; prga_n = 1;
    accept(24'h000155);
    adv(300);
    abort = 1'b1; ksa_wren = 1'b1;
    #1;
    chk("abort_cycle_wren", {63'd0, s_wren}, 64'd0);
    init_n = 4; ksa_n = 2; prga_n = 2;
    adv(1);
    ksa_wren = 1'b1;
    #1;
    chk("abort_phase", {62'd0, phase}, 64'd0);
    chk("abort_rdy",   {63'd0, rdy}, 64'd1);
    chk("abort_wren",  {63'd0, s_wren}, 64'd0);
    chk("abort_done",  {63'd0, done}, 64'd0);
    en = 1'b1; key = 24'h000999;   // restart in cycle 301
    cnt = 0; at = -1; dcnt = 0; dat = -1;
    for (int t = 302; t <= 410; t++) begin
      adv(1); #1;
      if (ksa_en) begin cnt++; at = t; end
      if (done) begin dcnt++; dat = t; end
      if (t == 350) chk("stall_phase", {62'd0, phase}, 64'd2);
    end
    chk("stall_ksa_en_count", 64'(cnt), 64'd1);
    chk("stall_ksa_en_cycle", 64'(at), 64'd400);
    chk("restart_done_count", 64'(dcnt), 64'd1);
    chk("restart_done_cycle", 64'(dat), 64'd408);

    // abort + en together in IDLE.
    adv(1);
    en = 1'b1; abort = 1'b1; key = 24'hFFFFFF;
    adv(1); #1;
    chk("ae_phase", {62'd0, phase}, 64'd0);
    chk("ae_key_q", {40'd0, key_q}, 64'h000999);
    chk("ae_init_en", {63'd0, init_en}, 64'd0);
    adv(1); #1;
    chk("ae_phase2", {62'd0, phase}, 64'd0);

    // abort coincident with prga completion (prga_rdy returns at cycle 12).
    init_n = 2; ksa_n = 2; prga_n = 2;
    accept(24'h0ABCDE);
    adv(12);
    abort = 1'b1;
    #1;
    chk("ap_phase", {62'd0, phase}, 64'd3);
    chk("ap_prga_rdy", {63'd0, prga_rdy}, 64'd1);
    adv(1); #1;
    chk("ap_done", {63'd0, done}, 64'd0);
    chk("ap_phase_idle", {62'd0, phase}, 64'd0);
    adv(1); #1;
    chk("ap_done2", {63'd0, done}, 64'd0);

    // Randomized passes against the timeline model.
    for (int r = 0; r < 8; r++) begin
      ni = $urandom_range(1, 12); nk = $urandom_range(1, 12); np = $urandom_range(1, 12);
      kr = KEY_W'($urandom);
      run_pass(kr, ni, nk, np, ni + 3, ni + nk + 5, ni + nk + np + 7, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
